// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared constants, rv32 typedefs and the highest-index match
//               helper used by the register file for write arbitration and
//               read bypass selection.
// Ports       : (package, none)
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;

   // Width of match vectors handed to hi_match_idx; caps write ports at 32.
   localparam int MATCH_W  = 32;

   typedef logic [4:0]  regaddr_t;
   typedef logic [31:0] xword_t;

   // Index of the highest set bit of vec (0 when vec is empty). When several
   // write ports hit the same register, the highest-index one owns it.
   function automatic regaddr_t hi_match_idx(input logic [MATCH_W-1:0] vec);
      regaddr_t idx;
      idx = '0;
      for (int i = 0; i < MATCH_W; i++) begin
         if (vec[i]) idx = i[4:0];
      end
      return idx;
   endfunction

endpackage : rv_pkg
`default_nettype wire

// File: rtl/rv_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rv_rf_scoreboard
// Description : Per-register pending bits. Priority on each clock edge:
//               flush > reserve > release. Register 0 is never pending.
// Ports       : clk, rst            - clock, async active-high reset
//               wr_en_i/wr_addr_i/wr_rel_i - writeback ports (release when
//                                    wr_en and wr_rel are both set)
//               rsv_en_i/rsv_addr_i - reservation from issue
//               flush_i             - clear all pending bits
//               busy_vec_o          - registered pending vector
// Revision    : 1.0 - initial release
// ============================================================================
module rv_rf_scoreboard
   import rv_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int NWP  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NWP-1:0]                wr_en_i,
   input  logic [NWP*$clog2(NREG)-1:0]   wr_addr_i,
   input  logic [NWP-1:0]                wr_rel_i,
   input  logic                          rsv_en_i,
   input  logic [$clog2(NREG)-1:0]       rsv_addr_i,
   input  logic                          flush_i,
   output logic [NREG-1:0]               busy_vec_o
);

   localparam int AW = $clog2(NREG);

   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;

   // Assignments are ordered lowest priority first so later ones win.
   always_comb begin
      pend_d = pend_q;
      for (int w = 0; w < NWP; w++) begin
         if (wr_en_i[w] && wr_rel_i[w]) pend_d[wr_addr_i[w*AW +: AW]] = 1'b0;
      end
      // The new producer owns the register, so reserve beats release.
      if (rsv_en_i) pend_d[rsv_addr_i] = 1'b1;
      if (flush_i)  pend_d = '0;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end

   assign busy_vec_o = pend_q;

endmodule : rv_rf_scoreboard
`default_nettype wire

// File: rtl/rv_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : rv_regfile_mp
// Description : Multi-port integer register file with optional write-to-read
//               bypass and a built-in pending scoreboard. x0 reads as zero.
// Ports       : clk, rst            - clock, async active-high reset
//               rd_addr_i           - NRP read addresses (AW bits each)
//               rd_data_o           - NRP read data words (combinational)
//               rd_busy_o           - pending bit of each addressed register
//               wr_en_i/wr_addr_i/wr_data_i/wr_rel_i - NWP writeback ports
//               rsv_en_i/rsv_addr_i - destination reservation from issue
//               flush_i             - clear all pending bits
//               busy_vec_o          - registered pending vector
// Revision    : 1.0 - initial release
// ============================================================================
module rv_regfile_mp
   import rv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int NRP    = 2,
   parameter int NWP    = 1,
   parameter int BYPASS = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NRP*$clog2(NREG)-1:0]   rd_addr_i,
   output logic [NRP*XLEN-1:0]           rd_data_o,
   output logic [NRP-1:0]                rd_busy_o,
   input  logic [NWP-1:0]                wr_en_i,
   input  logic [NWP*$clog2(NREG)-1:0]   wr_addr_i,
   input  logic [NWP*XLEN-1:0]           wr_data_i,
   input  logic [NWP-1:0]                wr_rel_i,
   input  logic                          rsv_en_i,
   input  logic [$clog2(NREG)-1:0]       rsv_addr_i,
   input  logic                          flush_i,
   output logic [NREG-1:0]               busy_vec_o
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0]    regs_q [NREG];
   logic [MATCH_W-1:0] wmatch [NREG];   // write ports targeting each register
   logic [MATCH_W-1:0] rmatch [NRP];    // write ports hitting each read address
   logic [AW-1:0]      raddr  [NRP];
   logic [NRP-1:0]     rel_hit;         // a releasing write hits this read
   logic [NREG-1:0]    pend;

   // ---------------------------------------------------------------- writes
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         wmatch[i] = '0;
         for (int w = 0; w < NWP; w++) begin
            wmatch[i][w] = wr_en_i[w] && (wr_addr_i[w*AW +: AW] == AW'(i));
         end
      end
   end

   // x0 is never written, so it holds its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (|wmatch[i]) begin
               regs_q[i] <= wr_data_i[int'(hi_match_idx(wmatch[i]))*XLEN +: XLEN];
            end
         end
      end
   end

   // ----------------------------------------------------------- scoreboard
   rv_rf_scoreboard #(
      .NREG (NREG),
      .NWP  (NWP)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .wr_rel_i   (wr_rel_i),
      .rsv_en_i   (rsv_en_i),
      .rsv_addr_i (rsv_addr_i),
      .flush_i    (flush_i),
      .busy_vec_o (pend)
   );

   assign busy_vec_o = pend;

   // ----------------------------------------------------------------- reads
   always_comb begin
      rd_data_o = '0;
      rd_busy_o = '0;
      rel_hit   = '0;
      for (int p = 0; p < NRP; p++) begin
         raddr[p]  = rd_addr_i[p*AW +: AW];
         rmatch[p] = '0;
         for (int w = 0; w < NWP; w++) begin
            rmatch[p][w] = wr_en_i[w] && (raddr[p] != '0) &&
                           (wr_addr_i[w*AW +: AW] == raddr[p]);
            if (rmatch[p][w] && wr_rel_i[w]) rel_hit[p] = 1'b1;
         end
         // Outputs stay at zero for the whole time reset is held.
         if (!rst) begin
            if ((BYPASS != 0) && (|rmatch[p])) begin
               rd_data_o[p*XLEN +: XLEN] =
                  wr_data_i[int'(hi_match_idx(rmatch[p]))*XLEN +: XLEN];
            end else begin
               rd_data_o[p*XLEN +: XLEN] = regs_q[raddr[p]];
            end
            // A releasing write delivers valid data through the bypass.
            rd_busy_o[p] = pend[raddr[p]] && !((BYPASS != 0) && rel_hit[p]);
         end
      end
   end

endmodule : rv_regfile_mp
`default_nettype wire

// File: tb/tb_rv_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_regfile_mp
// Description : Self-checking bench for rv_regfile_mp. Two instances (bypass
//               on and off, 2 read / 2 write ports) share the stimulus and
//               are compared every negedge against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int NRP  = 2;
   localparam int NWP  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NRP*AW-1:0]   rd_addr;
   logic [NRP*XLEN-1:0] rd_data, rd_data_nb;
   logic [NRP-1:0]      rd_busy, rd_busy_nb;
   logic [NWP-1:0]      wr_en;
   logic [NWP*AW-1:0]   wr_addr;
   logic [NWP*XLEN-1:0] wr_data;
   logic [NWP-1:0]      wr_rel;
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic                flush;
   logic [NREG-1:0]     busy_vec, busy_vec_nb;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b1;

   // Behavioural model state
   logic [XLEN-1:0] m_mem [NREG];
   logic [NREG-1:0] m_pend;

   rv_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
      .rd_busy_o(rd_busy), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .wr_rel_i(wr_rel), .rsv_en_i(rsv_en),
      .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_vec_o(busy_vec)
   );

   rv_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb),
      .rd_busy_o(rd_busy_nb), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .wr_rel_i(wr_rel), .rsv_en_i(rsv_en),
      .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_vec_o(busy_vec_nb)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ the model
   function automatic bit rel_at(input int i);
      bit r = 1'b0;
      for (int w = 0; w < NWP; w++)
         if (wr_en[w] && wr_rel[w] && int'(wr_addr[w*AW +: AW]) == i) r = 1'b1;
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) m_mem[i] = '0;
         m_pend = '0;
      end else begin
         // Pending rule, highest priority first, evaluated on pre-edge state.
         for (int i = 1; i < NREG; i++) begin
            if (flush)                                 m_pend[i] = 1'b0;
            else if (rsv_en && int'(rsv_addr) == i)    m_pend[i] = 1'b1;
            else if (rel_at(i))                        m_pend[i] = 1'b0;
         end
         m_pend[0] = 1'b0;
         // Ascending port order: the highest-index port lands last.
         for (int w = 0; w < NWP; w++)
            if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
               m_mem[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
      end
   end

   function automatic logic [31:0] exp_rd(input int p, input bit byp);
      int a;
      logic [31:0] d;
      if (rst) return '0;
      a = int'(rd_addr[p*AW +: AW]);
      d = (a == 0) ? 32'h0 : m_mem[a];
      if (byp)
         for (int w = 0; w < NWP; w++)
            if (wr_en[w] && a != 0 && int'(wr_addr[w*AW +: AW]) == a)
               d = wr_data[w*XLEN +: XLEN];
      return d;
   endfunction

   function automatic logic exp_busy(input int p, input bit byp);
      int a;
      logic b;
      if (rst) return 1'b0;
      a = int'(rd_addr[p*AW +: AW]);
      b = m_pend[a];
      if (byp && a != 0 && rel_at(a)) b = 1'b0;
      return b;
   endfunction

   // ------------------------------------------------------ compare process
   always @(negedge clk) begin
      if (cmp_on) begin
         for (int p = 0; p < NRP; p++) begin
            check($sformatf("byp rd_data%0d", p), rd_data[p*XLEN +: XLEN], exp_rd(p, 1'b1));
            check($sformatf("nb rd_data%0d", p), rd_data_nb[p*XLEN +: XLEN], exp_rd(p, 1'b0));
            check($sformatf("byp rd_busy%0d", p), 32'(rd_busy[p]), 32'(exp_busy(p, 1'b1)));
            check($sformatf("nb rd_busy%0d", p), 32'(rd_busy_nb[p]), 32'(exp_busy(p, 1'b0)));
         end
         check("byp busy_vec", busy_vec, rst ? 32'h0 : m_pend);
         check("nb busy_vec", busy_vec_nb, rst ? 32'h0 : m_pend);
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = '0; wr_addr = '0; wr_data = '0; wr_rel = '0;
      rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
   endtask

   function automatic logic [AW-1:0] raddr();
      if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, 31));
   endfunction

   initial begin
      rst = 1'b1;
      rd_addr = '0;
      idle();
      repeat (2) tick();
      #1;
      check("reset rd_data0", rd_data[31:0], 32'h0);
      check("reset busy_vec", busy_vec, 32'h0);

      // Write x5, read it back, then reset mid-run
      tick(); rst = 1'b0;
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
      tick(); idle(); rd_addr = {5'd0, 5'd5};
      #1 check("x5 stored", rd_data_nb[31:0], 32'hDEADBEEF);
      tick(); rst = 1'b1;
      #1 check("x5 during reset", rd_data[31:0], 32'h0);
      tick(); rst = 1'b0;
      #1 check("x5 after reset", rd_data[31:0], 32'h0);
      check("busy_vec after reset", busy_vec, 32'h0);

      // x0 immunity
      tick();
      wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h12345678};
      wr_rel = 2'b01; rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr = {5'd0, 5'd0};
      #1 check("x0 bypass", rd_data[31:0], 32'h0);
      tick(); idle();
      #1 check("x0 read", rd_data[31:0], 32'h0);
      check("x0 busy_vec", busy_vec, 32'h0);

      // Bypass and write latency
      tick();
      wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hA5A5A5A5};
      rd_addr = {5'd7, 5'd0};
      #1 check("x7 bypass", rd_data[63:32], 32'hA5A5A5A5);
      check("x7 no bypass", rd_data_nb[63:32], 32'h0);
      tick(); idle();
      #1 check("x7 next cycle", rd_data_nb[63:32], 32'hA5A5A5A5);

      // Write conflict on x3
      tick();
      wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h2, 32'h1};
      rd_addr = {5'd0, 5'd3};
      #1 check("x3 conflict bypass", rd_data[31:0], 32'h2);
      tick(); idle(); rd_addr = {5'd3, 5'd3};
      #1 check("x3 stored", rd_data_nb[31:0], 32'h2);

      // Scoreboard lifecycle on x9
      tick(); rsv_en = 1'b1; rsv_addr = 5'd9;
      tick(); idle(); rd_addr = {5'd9, 5'd9};
      #1 check("x9 busy_vec", busy_vec, 32'h0000_0200);
      check("x9 rd_busy", 32'(rd_busy), 32'h3);
      tick();
      wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h77};
      wr_rel = 2'b01; rd_addr = {5'd9, 5'd0};
      #1 check("x9 release rd_busy", 32'(rd_busy[1]), 32'h0);
      check("x9 release data", rd_data[63:32], 32'h77);
      check("x9 release nb busy", 32'(rd_busy_nb[1]), 32'h1);
      tick(); idle();
      #1 check("x9 released", busy_vec, 32'h0);

      // Priority corners
      tick();
      rsv_en = 1'b1; rsv_addr = 5'd4;
      wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h44}; wr_rel = 2'b01;
      tick(); idle(); rsv_en = 1'b1; rsv_addr = 5'd6;
      #1 check("rsv beats release", busy_vec, 32'h0000_0010);
      tick(); idle(); flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd6;
      #1 check("x4 x6 pending", busy_vec, 32'h0000_0050);
      tick(); idle();
      #1 check("flush beats rsv", busy_vec, 32'h0);

      // Randomized phase
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst = ($urandom_range(0, 199) == 0);
         for (int w = 0; w < NWP; w++) begin
            wr_en[w] = 1'($urandom_range(0, 1));
            wr_rel[w] = 1'($urandom_range(0, 1));
            wr_addr[w*AW +: AW] = raddr();
            wr_data[w*XLEN +: XLEN] = $urandom;
         end
         for (int p = 0; p < NRP; p++) rd_addr[p*AW +: AW] = raddr();
         rsv_en = ($urandom_range(0, 3) == 0);
         rsv_addr = raddr();
         flush = ($urandom_range(0, 31) == 0);
      end

      tick(); idle(); rst = 1'b0;
      repeat (2) tick();
      cmp_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rv_regfile_mp
`default_nettype wire
